// File: rtl/vsm_stream.sv
// -----------------------------------------------------------------------------
// vsm_stream -- streaming vector-scalar multiply-accumulate.
//
// Each accepted beat multiplies SIZE signed lanes of `a` by the signed scalar
// `b` and adds the products into per-lane accumulators. After ACCUMULATIONS
// beats the accumulators are arithmetically shifted right by SHIFT. They are
// optionally rectified and then saturated to OUT_WIDTH. The resulting vector
// is presented on a valid/ready output port.
//
// Optional feature (macro VSM_STREAM_RELU_EN):
//   defined   -> negative shifted results are forced to zero before saturation
//   undefined -> shifted results pass to saturation unchanged
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   clear      in   synchronous abort of the partial accumulation group
//   in_valid   in   beat valid
//   in_ready   out  beat accepted when in_valid && in_ready
//   a          in   WIDTH*SIZE, lane i at [WIDTH*i +: WIDTH], signed
//   b          in   WIDTH, signed scalar
//   out_valid  out  result vector valid
//   out_ready  in   downstream accepts when out_valid && out_ready
//   out        out  OUT_WIDTH*SIZE, lane i at [OUT_WIDTH*i +: OUT_WIDTH], signed
//   busy       out  group in progress or result pending
// -----------------------------------------------------------------------------
module vsm_stream #(
    parameter int SIZE          = 6,
    parameter int WIDTH         = 8,
    parameter int ACC_WIDTH     = 20,
    parameter int ACCUMULATIONS = 3,
    parameter int OUT_WIDTH     = 8,
    parameter int SHIFT         = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH*SIZE-1:0]     a,
    input  logic [WIDTH-1:0]          b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_WIDTH*SIZE-1:0] out,
    output logic                      busy
);

    if (ACCUMULATIONS < 1) begin : g_bad_accumulations
        $error("vsm_stream: ACCUMULATIONS must be >= 1");
    end
    if (ACC_WIDTH < 2*WIDTH + $clog2(ACCUMULATIONS)) begin : g_bad_acc_width
        $error("vsm_stream: ACC_WIDTH too small for 2*WIDTH + clog2(ACCUMULATIONS)");
    end

    localparam int CNT_W = (ACCUMULATIONS > 1) ? $clog2(ACCUMULATIONS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(ACCUMULATIONS - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((2**(OUT_WIDTH-1)) - 1);
    // Bitwise inverse of the positive limit is exactly -2^(OUT_WIDTH-1).
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic signed [ACC_WIDTH-1:0]   acc_q [SIZE];
    logic signed [ACC_WIDTH-1:0]   acc_d [SIZE];
    logic signed [ACC_WIDTH-1:0]   acc_next [SIZE];
    logic [OUT_WIDTH*SIZE-1:0]     out_q, out_d, out_next;
    logic                          out_valid_q, out_valid_d;
    logic                          accept;
    logic                          last_beat;
    logic signed [WIDTH-1:0]       b_s;

    assign b_s       = b;
    assign in_ready  = !clear && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign last_beat = accept && (cnt_q == LAST_BEAT);
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign busy      = (cnt_q != '0) || out_valid_q;

    // Per-lane datapath: multiply, accumulate, shift, rectify, saturate.
    for (genvar i = 0; i < SIZE; i++) begin : g_lane
        logic signed [WIDTH-1:0]     a_lane;
        logic signed [2*WIDTH-1:0]   prod;
        logic signed [ACC_WIDTH-1:0] acc_base;
        logic signed [ACC_WIDTH-1:0] scaled;
        logic signed [ACC_WIDTH-1:0] rect;

        assign a_lane = a[WIDTH*i +: WIDTH];
        assign prod   = (2*WIDTH)'(a_lane) * (2*WIDTH)'(b_s);
        // The first beat of a group overwrites, so clear never has to zero acc.
        assign acc_base    = (cnt_q == '0) ? '0 : acc_q[i];
        assign acc_next[i] = acc_base + ACC_WIDTH'(prod);
        assign scaled      = acc_next[i] >>> SHIFT;
`ifdef VSM_STREAM_RELU_EN
        assign rect = scaled[ACC_WIDTH-1] ? '0 : scaled;
`else
        assign rect = scaled;
`endif
        assign out_next[OUT_WIDTH*i +: OUT_WIDTH] =
            (rect > SAT_MAX) ? OUT_WIDTH'(SAT_MAX) :
            (rect < SAT_MIN) ? OUT_WIDTH'(SAT_MIN) :
                               OUT_WIDTH'(rect);
    end

    // NOTE: every signal driven here gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    always_comb begin
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;

        if (clear) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = last_beat ? '0 : cnt_q + CNT_W'(1);
        end

        for (int i = 0; i < SIZE; i++) begin
            if (accept) begin
                acc_d[i] = acc_next[i];
            end
        end

        // A new result wins over a completing handshake in the same cycle.
        if (last_beat) begin
            out_valid_d = 1'b1;
            out_d       = out_next;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: the accumulator array is reset along with the control state
    // because reset must discard any partial group; it is small flop storage,
    // not a RAM, so resetting it costs nothing structural.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < SIZE; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so all registers update from the
            // same pre-edge values.
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            for (int i = 0; i < SIZE; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

endmodule

// File: tb/tb_vsm_stream.sv
// -----------------------------------------------------------------------------
// tb_vsm_stream -- directed self-checking bench for vsm_stream with default
// parameters (SIZE=6, WIDTH=8, ACCUMULATIONS=3, SHIFT=0, OUT_WIDTH=8).
// Expected values are hand-computed constants; VSM_STREAM_RELU_EN selects the
// rectified variants.
// -----------------------------------------------------------------------------
module tb_vsm_stream;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] out;
    logic        busy;

    int total = 0;
    int bad   = 0;

    vsm_stream dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [47:0] lanes(input logic [7:0] v);
        return {6{v}};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [47:0] av, input logic [7:0] bv);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        tick();
    endtask

    // Mixed-sign vector [1,-1,5,-5,0,10], lane 0 in the low byte.
    localparam logic [47:0] MIXED_A = {8'h0A, 8'h00, 8'hFB, 8'h05, 8'hFF, 8'h01};
`ifdef VSM_STREAM_RELU_EN
    localparam logic [47:0] MIXED_EXP = {8'h1E, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h03};
    localparam logic [7:0]  NEG_SAT   = 8'h00;
`else
    localparam logic [47:0] MIXED_EXP = {8'h1E, 8'h00, 8'hF1, 8'h0F, 8'hFD, 8'h03};
    localparam logic [7:0]  NEG_SAT   = 8'h80;
`endif

    initial begin
        reset     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        tick();
        tick();

        // Reset state
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out",       64'(out),       64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        reset = 1'b1;
        tick();

        // Basic: 2*3 over three beats -> 18 per lane
        beat(lanes(8'd2), 8'd3);
        beat(lanes(8'd2), 8'd3);
        check("basic_mid_busy",  64'(busy),      64'd1);
        check("basic_mid_valid", 64'(out_valid), 64'd0);
        beat(lanes(8'd2), 8'd3);
        in_valid = 1'b0;
        check("basic_valid", 64'(out_valid), 64'd1);
        check("basic_out",   64'(out),       64'(lanes(8'd18)));
        tick();
        check("basic_valid_drop", 64'(out_valid), 64'd0);
        check("basic_out_kept",   64'(out),       64'(lanes(8'd18)));
        check("basic_idle_busy",  64'(busy),      64'd0);

        // Signed / mixed lanes: b = 2, 2, -1
        beat(MIXED_A, 8'd2);
        beat(MIXED_A, 8'd2);
        beat(MIXED_A, 8'hFF);
        in_valid = 1'b0;
        check("mixed_valid", 64'(out_valid), 64'd1);
        check("mixed_out",   64'(out),       64'(MIXED_EXP));
        tick();

        // Saturation, both groups back to back
        beat(lanes(8'h7F), 8'h7F);
        beat(lanes(8'h7F), 8'h7F);
        beat(lanes(8'h7F), 8'h7F);
        check("sat_pos_out", 64'(out), 64'(lanes(8'h7F)));
        beat(lanes(8'h80), 8'h7F);
        check("sat_handshake_drop", 64'(out_valid), 64'd0);
        beat(lanes(8'h80), 8'h7F);
        beat(lanes(8'h80), 8'h7F);
        in_valid = 1'b0;
        check("sat_neg_valid", 64'(out_valid), 64'd1);
        check("sat_neg_out",   64'(out),       64'(lanes(NEG_SAT)));
        tick();

        // Backpressure: result held for 5 cycles while a beat waits
        out_ready = 1'b0;
        beat(lanes(8'd2), 8'd3);
        beat(lanes(8'd2), 8'd3);
        beat(lanes(8'd2), 8'd3);
        a = lanes(8'd1);
        b = 8'd1;
        for (int k = 0; k < 5; k++) begin
            check("bp_valid_held", 64'(out_valid), 64'd1);
            check("bp_out_held",   64'(out),       64'(lanes(8'd18)));
            check("bp_in_ready",   64'(in_ready),  64'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(in_ready), 64'd1);
        tick();
        check("bp_valid_drop", 64'(out_valid), 64'd0);
        check("bp_busy_group", 64'(busy),      64'd1);
        check("bp_out_kept",   64'(out),       64'(lanes(8'd18)));
        beat(lanes(8'd1), 8'd1);
        beat(lanes(8'd1), 8'd1);
        in_valid = 1'b0;
        check("bp_group_valid", 64'(out_valid), 64'd1);
        check("bp_group_out",   64'(out),       64'(lanes(8'd3)));
        tick();

        // Clear aborts a partial group
        beat(lanes(8'd9), 8'd9);
        beat(lanes(8'd9), 8'd9);
        clear = 1'b1;
        a     = lanes(8'd1);
        b     = 8'd1;
        #1;
        check("clr_in_ready", 64'(in_ready), 64'd0);
        tick();
        clear = 1'b0;
        check("clr_busy",  64'(busy),      64'd0);
        check("clr_valid", 64'(out_valid), 64'd0);
        beat(lanes(8'd1), 8'd1);
        beat(lanes(8'd1), 8'd1);
        check("clr_no_early_result", 64'(out_valid), 64'd0);
        beat(lanes(8'd1), 8'd1);
        in_valid = 1'b0;
        check("clr_result_valid", 64'(out_valid), 64'd1);
        check("clr_result_out",   64'(out),       64'(lanes(8'd3)));
        tick();

        // Reset in the middle of a group
        beat(lanes(8'd2), 8'd3);
        beat(lanes(8'd2), 8'd3);
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("rstmid_valid", 64'(out_valid), 64'd0);
        check("rstmid_out",   64'(out),       64'd0);
        check("rstmid_busy",  64'(busy),      64'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        beat(lanes(8'd2), 8'd3);
        beat(lanes(8'd2), 8'd3);
        beat(lanes(8'd2), 8'd3);
        in_valid = 1'b0;
        check("rstmid_after_valid", 64'(out_valid), 64'd1);
        check("rstmid_after_out",   64'(out),       64'(lanes(8'd18)));
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
